// File: rtl/uart_ram_bridge.sv
// UART byte-stream to single-access SRAM command sequencer (write 0x57, read 0x52).
// Define UART_RAM_ECHO_ACK_EN to answer each successful write with 0x4B.
module uart_ram_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        mem_en_n,
  output logic        mem_re_n,
  output logic        mem_we_n,
  output logic [16:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        busy,
  output logic        err
);

  localparam logic [7:0] OP_WR     = 8'h57;
  localparam logic [7:0] OP_RD     = 8'h52;
  localparam logic [7:0] ACK_BYTE  = 8'h4B;
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    MEM_ACC,
    SEND_HI,
    SEND_LO
`ifdef UART_RAM_ECHO_ACK_EN
    , SEND_ACK
`endif
  } state_t;

  state_t      state;
  logic        is_write;
  logic        issued;
  logic [1:0]  bcnt;
  logic [7:0]  tcnt;
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      issued    <= 1'b0;
      bcnt      <= 2'd0;
      tcnt      <= 8'd0;
      rdata_q   <= 16'h0000;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      mem_en_n  <= 1'b1;
      mem_re_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_addr  <= 17'h0;
      mem_wdata <= 16'h0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == OP_WR || rx_data == OP_RD)) begin
            is_write <= (rx_data == OP_WR);
            err      <= 1'b0;
            bcnt     <= 2'd0;
            busy     <= 1'b1;
            state    <= GET_ADDR;
          end
        end
        // Address bytes land directly in mem_addr; strobes stay high until the access starts.
        GET_ADDR: begin
          if (rx_valid) begin
            case (bcnt)
              2'd0:    mem_addr[16]   <= rx_data[0];
              2'd1:    mem_addr[15:8] <= rx_data;
              default: mem_addr[7:0]  <= rx_data;
            endcase
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd2) begin
              bcnt <= 2'd0;
              if (is_write) begin
                state <= GET_DATA;
              end else begin
                issued <= 1'b0;
                tcnt   <= 8'd0;
                state  <= MEM_ACC;
              end
            end
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            if (bcnt == 2'd0) begin
              mem_wdata[15:8] <= rx_data;
              bcnt            <= 2'd1;
            end else begin
              mem_wdata[7:0] <= rx_data;
              bcnt           <= 2'd0;
              issued         <= 1'b0;
              tcnt           <= 8'd0;
              state          <= MEM_ACC;
            end
          end
        end
        // First cycle is address setup; strobes fall on the following edge.
        MEM_ACC: begin
          if (!issued) begin
            issued   <= 1'b1;
            mem_en_n <= 1'b0;
            mem_re_n <= is_write;
            mem_we_n <= !is_write;
          end else if (mem_done) begin
            mem_en_n <= 1'b1;
            mem_re_n <= 1'b1;
            mem_we_n <= 1'b1;
            if (is_write) begin
`ifdef UART_RAM_ECHO_ACK_EN
              state <= SEND_ACK;
`else
              busy  <= 1'b0;
              state <= IDLE;
`endif
            end else begin
              rdata_q <= mem_rdata;
              state   <= SEND_HI;
            end
          end else if (tcnt == TCNT_LAST) begin
            mem_en_n <= 1'b1;
            mem_re_n <= 1'b1;
            mem_we_n <= 1'b1;
            err      <= 1'b1;
            if (is_write) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              rdata_q <= 16'hEEEE;
              state   <= SEND_HI;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        // Skipping the cycle tx_valid is high gives the transmitter time to drop tx_ready.
        SEND_HI: begin
          if (tx_ready && !tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= rdata_q[15:8];
            state    <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (tx_ready && !tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= rdata_q[7:0];
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
`ifdef UART_RAM_ECHO_ACK_EN
        SEND_ACK: begin
          if (tx_ready && !tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= ACK_BYTE;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef UART_RAM_ECHO_ACK_EN
  logic unused_ack;
  assign unused_ack = ^ACK_BYTE;
`endif

endmodule

// File: tb/tb_uart_ram_bridge.sv
// Directed self-checking bench for uart_ram_bridge; honours UART_RAM_ECHO_ACK_EN.
module tb_uart_ram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        mem_en_n;
  logic        mem_re_n;
  logic        mem_we_n;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;

  uart_ram_bridge #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .mem_en_n(mem_en_n), .mem_re_n(mem_re_n), .mem_we_n(mem_we_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Transmitter model plus memory-strobe monitor, sampled on the falling edge.
  logic [7:0]  tx_q[$];
  int          tx_busy = 0;
  int          tx_pulses = 0;
  logic        hold_ready = 1'b0;
  int          we_low = 0;
  int          re_low = 0;
  int          both_low = 0;
  int          accesses = 0;
  int          addr_unstable = 0;
  logic        prev_en_n = 1'b1;
  logic [16:0] prev_addr = 17'h0;

  assign tx_ready = !hold_ready && (tx_busy == 0);

  always @(negedge clk) begin
    if (tx_valid === 1'b1) begin
      tx_q.push_back(tx_data);
      tx_pulses <= tx_pulses + 1;
      tx_busy   <= 4;
    end else if (tx_busy > 0) begin
      tx_busy <= tx_busy - 1;
    end
    if (mem_we_n === 1'b0) we_low <= we_low + 1;
    if (mem_re_n === 1'b0) re_low <= re_low + 1;
    if (mem_we_n === 1'b0 && mem_re_n === 1'b0) both_low <= both_low + 1;
    if (prev_en_n === 1'b1 && mem_en_n === 1'b0) begin
      accesses <= accesses + 1;
      if (mem_addr !== prev_addr) addr_unstable <= addr_unstable + 1;
    end
    prev_en_n <= mem_en_n;
    prev_addr <= mem_addr;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_en_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tx(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; mem_done = 1'b0; mem_rdata = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_valid, tx_data, mem_en_n, mem_re_n, mem_we_n, mem_addr, mem_wdata, busy, err} !==
        {1'b0, 8'h00, 3'b111, 17'h0, 16'h0, 2'b00}) begin
      failures++;
      $display("FAIL reset_state got en/re/we=%b%b%b addr=%h wd=%h busy=%b err=%b txv=%b txd=%h",
               mem_en_n, mem_re_n, mem_we_n, mem_addr, mem_wdata, busy, err, tx_valid, tx_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    int we0 = we_low, re0 = re_low, acc0 = accesses, txb = tx_q.size();
    bit ok;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'hBE); send_byte(8'hEF);
    checks++;
    if (mem_en_n !== 1'b1 || mem_addr !== 17'h01234) begin
      failures++;
      $display("FAIL write_setup got en_n=%b addr=%h exp en_n=1 addr=01234", mem_en_n, mem_addr);
    end
    wait_en_low(ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL write_en_wait got timeout exp mem_en_n=0"); end
    checks++;
    if (mem_addr !== 17'h01234 || mem_wdata !== 16'hBEEF || mem_we_n !== 1'b0 || mem_re_n !== 1'b1) begin
      failures++;
      $display("FAIL write_access got addr=%h wd=%h we_n=%b re_n=%b exp 01234 BEEF 0 1",
               mem_addr, mem_wdata, mem_we_n, mem_re_n);
    end
    @(negedge clk);
    @(negedge clk);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    checks++;
    if ({mem_en_n, mem_re_n, mem_we_n} !== 3'b111) begin
      failures++;
      $display("FAIL write_release got en/re/we=%b%b%b exp 111", mem_en_n, mem_re_n, mem_we_n);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (we_low - we0 !== 3 || re_low - re0 !== 0 || accesses - acc0 !== 1) begin
      failures++;
      $display("FAIL write_strobes got we_cycles=%0d re_cycles=%0d accesses=%0d exp 3 0 1",
               we_low - we0, re_low - re0, accesses - acc0);
    end
`ifdef UART_RAM_ECHO_ACK_EN
    checks++;
    if (tx_q.size() !== txb + 1) begin
      failures++;
      $display("FAIL write_ack_count got=%0d exp=1", tx_q.size() - txb);
    end else if (tx_q[txb] !== 8'h4B) begin
      failures++;
      $display("FAIL write_ack_byte got=%h exp=4b", tx_q[txb]);
    end
`else
    checks++;
    if (tx_q.size() !== txb) begin
      failures++;
      $display("FAIL write_no_tx got=%0d bytes exp=0", tx_q.size() - txb);
    end
`endif
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL write_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_read_ram2();
    int txb = tx_q.size();
    bit ok;
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    wait_en_low(ok);
    checks++;
    if (ok !== 1'b1 || mem_addr !== 17'h10005 || mem_re_n !== 1'b0 || mem_we_n !== 1'b1) begin
      failures++;
      $display("FAIL read_access got ok=%b addr=%h re_n=%b we_n=%b exp 1 10005 0 1",
               ok, mem_addr, mem_re_n, mem_we_n);
    end
    mem_rdata = 16'hA55A;
    mem_done  = 1'b1;
    @(negedge clk);
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL read_first_tx got valid=%b data=%h exp 1 a5", tx_valid, tx_data);
    end
    wait_tx(txb + 2, ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL read_tx_wait got %0d bytes exp 2", tx_q.size() - txb);
    end else if (tx_q[txb] !== 8'hA5 || tx_q[txb+1] !== 8'h5A) begin
      failures++;
      $display("FAIL read_tx_bytes got %h %h exp a5 5a", tx_q[txb], tx_q[txb+1]);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL read_idle got busy=%b err=%b exp 0 0", busy, err);
    end
  endtask

  task automatic test_timeout();
    int txb = tx_q.size();
    int cnt;
    bit ok;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    wait_en_low(ok);
    cnt = ok ? 1 : 0;
    for (int i = 0; i < 400 && ok; i++) begin
      @(negedge clk);
      if (mem_en_n === 1'b0) cnt++;
      else break;
    end
    checks++;
    if (cnt !== 255) begin failures++; $display("FAIL timeout_cycles got=%0d exp=255", cnt); end
    checks++;
    if (err !== 1'b1 || {mem_en_n, mem_re_n, mem_we_n} !== 3'b111) begin
      failures++;
      $display("FAIL timeout_err got err=%b strobes=%b%b%b exp 1 111", err, mem_en_n, mem_re_n, mem_we_n);
    end
    wait_tx(txb + 2, ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL timeout_tx_wait got %0d bytes exp 2", tx_q.size() - txb);
    end else if (tx_q[txb] !== 8'hEE || tx_q[txb+1] !== 8'hEE) begin
      failures++;
      $display("FAIL timeout_tx_bytes got %h %h exp ee ee", tx_q[txb], tx_q[txb+1]);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_sticky got err=%b busy=%b exp 1 0", err, busy);
    end
    txb = tx_q.size();
    send_byte(8'h52);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL err_clear got err=%b busy=%b exp 0 1", err, busy);
    end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    wait_en_low(ok);
    mem_rdata = 16'h0102;
    mem_done  = 1'b1;
    @(negedge clk);
    mem_done  = 1'b0;
    wait_tx(txb + 2, ok);
    checks++;
    if (ok !== 1'b1 || tx_q[txb] !== 8'h01 || tx_q[txb+1] !== 8'h02 || err !== 1'b0) begin
      failures++;
      $display("FAIL after_timeout_read got ok=%b err=%b exp bytes 01 02 err 0", ok, err);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_garbage();
    int acc0 = accesses, txb;
    bit ok;
    send_byte(8'h00); send_byte(8'hFF);
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || accesses !== acc0 || mem_en_n !== 1'b1) begin
      failures++;
      $display("FAIL garbage_ignored got busy=%b accesses=%0d en_n=%b exp 0 0 1",
               busy, accesses - acc0, mem_en_n);
    end
    txb = tx_q.size();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    wait_en_low(ok);
    send_byte(8'h57);
    send_byte(8'h52);
    mem_rdata = 16'h1234;
    mem_done  = 1'b1;
    @(negedge clk);
    mem_done  = 1'b0;
    wait_tx(txb + 2, ok);
    checks++;
    if (ok !== 1'b1 || tx_q[txb] !== 8'h12 || tx_q[txb+1] !== 8'h34) begin
      failures++;
      $display("FAIL drop_rx_read got ok=%b count=%0d exp bytes 12 34", ok, tx_q.size() - txb);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || accesses - acc0 !== 1) begin
      failures++;
      $display("FAIL drop_rx_idle got busy=%b accesses=%0d exp 0 1", busy, accesses - acc0);
    end
  endtask

  task automatic test_backpressure();
    int txb = tx_q.size(), p0;
    bit ok;
    hold_ready = 1'b1;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h09);
    wait_en_low(ok);
    mem_rdata = 16'hC33C;
    mem_done  = 1'b1;
    @(negedge clk);
    mem_done  = 1'b0;
    p0 = tx_pulses;
    repeat (100) @(negedge clk);
    checks++;
    if (tx_pulses !== p0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold got pulses=%0d busy=%b exp 0 1", tx_pulses - p0, busy);
    end
    hold_ready = 1'b0;
    wait_tx(txb + 2, ok);
    checks++;
    if (ok !== 1'b1 || tx_q[txb] !== 8'hC3 || tx_q[txb+1] !== 8'h3C) begin
      failures++;
      $display("FAIL bp_bytes got ok=%b count=%0d exp c3 3c", ok, tx_q.size() - txb);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (tx_pulses - p0 !== 2) begin
      failures++;
      $display("FAIL bp_pulses got=%0d exp=2", tx_pulses - p0);
    end
  endtask

  task automatic test_reset_mid();
    int txb;
    bit ok;
    send_byte(8'h57); send_byte(8'h01); send_byte(8'hFF);
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h11);
    wait_en_low(ok);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ok !== 1'b1 || {mem_en_n, mem_re_n, mem_we_n} !== 3'b111 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got ok=%b strobes=%b%b%b busy=%b exp 1 111 0",
               ok, mem_en_n, mem_re_n, mem_we_n, busy);
    end
    rst = 1'b0;
    send_byte(8'h52); send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    repeat (6) @(negedge clk);
    txb = tx_q.size();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
    wait_en_low(ok);
    checks++;
    if (ok !== 1'b1 || mem_addr !== 17'h00003 || mem_re_n !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_access got ok=%b addr=%h re_n=%b exp 1 00003 0", ok, mem_addr, mem_re_n);
    end
    mem_rdata = 16'h7788;
    mem_done  = 1'b1;
    @(negedge clk);
    mem_done  = 1'b0;
    wait_tx(txb + 2, ok);
    checks++;
    if (ok !== 1'b1 || tx_q[txb] !== 8'h77 || tx_q[txb+1] !== 8'h88) begin
      failures++;
      $display("FAIL post_reset_bytes got ok=%b count=%0d exp 77 88", ok, tx_q.size() - txb);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_protocol();
    checks++;
    if (both_low !== 0 || addr_unstable !== 0) begin
      failures++;
      $display("FAIL protocol got both_low=%0d addr_unstable=%0d exp 0 0", both_low, addr_unstable);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; mem_done = 1'b0; mem_rdata = 16'h0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read_ram2();
    test_timeout();
    test_garbage();
    test_backpressure();
    test_reset_mid();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
